// File: rtl/demux1t2_32_stream_pkg.sv
// Shared constants for the multiplex/arithmetic datapath blocks.
// The select encodings follow the 2:1 selector's I0/I1 convention.
package demux1t2_32_stream_pkg;

  localparam int DW_DEFAULT = 32;

  localparam logic SEL_O0 = 1'b0;
  localparam logic SEL_O1 = 1'b1;

endpackage : demux1t2_32_stream_pkg

// File: rtl/demux1t2_32_stream_fifo.sv
// Per-output FIFO with registered, reset-to-zero storage.
// Uses extra-MSB pointers so that full and empty can be told apart.
module stream_fifo_32 #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic          do_wr;
  logic          do_rd;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Guard internally so a misbehaving caller cannot corrupt occupancy.
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_wr) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule : stream_fifo_32

// File: rtl/demux1t2_32_stream.sv
// 1:2 stream demultiplexer: steers each accepted word to one of two
// buffered outputs by its select bit and counts words delivered per output.
module demux1t2_32_stream
  import demux1t2_32_stream_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sel,
  input  logic [DW-1:0] in_data,
  output logic          o0_valid,
  input  logic          o0_ready,
  output logic [DW-1:0] o0_data,
  output logic          o1_valid,
  input  logic          o1_ready,
  output logic [DW-1:0] o1_data,
  output logic [31:0]   cnt0,
  output logic [31:0]   cnt1
);

  logic        full0, full1;
  logic        empty0, empty1;
  logic        accept;
  logic        wr_en0, wr_en1;
  logic        rd_en0, rd_en1;
  logic [31:0] cnt0_q, cnt0_d;
  logic [31:0] cnt1_q, cnt1_d;

  // Ready looks only at the selected FIFO's registered full flag.
  assign in_ready = (in_sel == SEL_O1) ? !full1 : !full0;
  assign accept   = in_valid && in_ready;
  assign wr_en0   = accept && (in_sel == SEL_O0);
  assign wr_en1   = accept && (in_sel == SEL_O1);

  assign o0_valid = !empty0;
  assign o1_valid = !empty1;
  assign rd_en0   = o0_valid && o0_ready;
  assign rd_en1   = o1_valid && o1_ready;

  stream_fifo_32 #(.DW(DW), .DEPTH(DEPTH)) u_fifo0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en0),
    .wr_data (in_data),
    .full    (full0),
    .rd_en   (rd_en0),
    .rd_data (o0_data),
    .empty   (empty0)
  );

  stream_fifo_32 #(.DW(DW), .DEPTH(DEPTH)) u_fifo1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en1),
    .wr_data (in_data),
    .full    (full1),
    .rd_en   (rd_en1),
    .rd_data (o1_data),
    .empty   (empty1)
  );

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (rd_en0) cnt0_d = cnt0_q + 32'd1;
    if (rd_en1) cnt1_d = cnt1_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;

endmodule : demux1t2_32_stream

// File: tb/tb_demux1t2_32_stream.sv
// Bench for demux1t2_32_stream: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_demux1t2_32_stream;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_sel;
  logic [DW-1:0] in_data;
  logic          o0_valid, o0_ready, o1_valid, o1_ready;
  logic [DW-1:0] o0_data, o1_data;
  logic [31:0]   cnt0, cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] m_cnt0, m_cnt1;
  logic        m_acc, m_pop0, m_pop1;

  demux1t2_32_stream #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .o0_valid (o0_valid),
    .o0_ready (o0_ready),
    .o0_data  (o0_data),
    .o1_valid (o1_valid),
    .o1_ready (o1_ready),
    .o1_data  (o1_data),
    .cnt0     (cnt0),
    .cnt1     (cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy and order from plain queues.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      m_cnt0 = '0;
      m_cnt1 = '0;
    end else begin
      m_acc  = in_valid && ((in_sel ? q1.size() : q0.size()) < DEPTH);
      m_pop0 = o0_ready && (q0.size() > 0);
      m_pop1 = o1_ready && (q1.size() > 0);
      if (m_pop0) begin void'(q0.pop_front()); m_cnt0 = m_cnt0 + 32'd1; end
      if (m_pop1) begin void'(q1.pop_front()); m_cnt1 = m_cnt1 + 32'd1; end
      if (m_acc) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, ((in_sel ? q1.size() : q0.size()) < DEPTH)});
      check("o0_valid", {31'd0, o0_valid}, {31'd0, (q0.size() != 0)});
      check("o1_valid", {31'd0, o1_valid}, {31'd0, (q1.size() != 0)});
      if (q0.size() != 0) check("o0_data", o0_data, q0[0]);
      if (q1.size() != 0) check("o1_data", o1_data, q1[0]);
      check("cnt0", cnt0, m_cnt0);
      check("cnt1", cnt1, m_cnt1);
    end
  end

  // Inputs change 2 time units after each rising edge.
  task automatic cycle(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    o0_ready = 1'b0; o1_ready = 1'b0;
    cycle(3);
    rst_n = 1'b1;
    cycle(1);

    // Reset state
    check("rst_o0_valid", {31'd0, o0_valid}, 32'd0);
    check("rst_o1_valid", {31'd0, o1_valid}, 32'd0);
    check("rst_cnt0", cnt0, 32'd0);
    check("rst_cnt1", cnt1, 32'd0);
    check("rst_o0_data", o0_data, 32'd0);
    check("rst_o1_data", o1_data, 32'd0);
    in_sel = 1'b0; #1 check("rst_ready_sel0", {31'd0, in_ready}, 32'd1);
    in_sel = 1'b1; #1 check("rst_ready_sel1", {31'd0, in_ready}, 32'd1);

    // Routing
    o0_ready = 1'b1; o1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hA5A5_0001;
    cycle(1);
    check("route_o0_valid", {31'd0, o0_valid}, 32'd1);
    check("route_o0_data", o0_data, 32'hA5A5_0001);
    check("route_o1_idle", {31'd0, o1_valid}, 32'd0);
    in_sel = 1'b1; in_data = 32'h5A5A_0002;
    cycle(1);
    check("route_o1_valid", {31'd0, o1_valid}, 32'd1);
    check("route_o1_data", o1_data, 32'h5A5A_0002);
    check("route_o0_drained", {31'd0, o0_valid}, 32'd0);
    check("route_cnt0", cnt0, 32'd1);
    in_valid = 1'b0;
    cycle(1);
    check("route_cnt1", cnt1, 32'd1);
    check("route_o1_drained", {31'd0, o1_valid}, 32'd0);

    // Full and back-pressure on output 0
    o0_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_data = i;
      #1 check("full_ready_pre", {31'd0, in_ready}, 32'd1);
      cycle(1);
    end
    in_data = 32'd5;
    #1 check("full_ready_low", {31'd0, in_ready}, 32'd0);
    cycle(1);
    check("full_still_low", {31'd0, in_ready}, 32'd0);
    in_sel = 1'b1; in_data = 32'h0000_0077;
    #1 check("full_other_ready", {31'd0, in_ready}, 32'd1);
    cycle(1);
    check("full_other_data", o1_data, 32'h0000_0077);
    in_sel = 1'b0; in_data = 32'd5; o0_ready = 1'b1;
    check("full_head1", o0_data, 32'd1);
    cycle(1);
    o0_ready = 1'b0;
    check("full_ready_freed", {31'd0, in_ready}, 32'd1);
    cycle(1);
    in_valid = 1'b0; o0_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      check("full_order", o0_data, k);
      cycle(1);
    end
    check("full_empty", {31'd0, o0_valid}, 32'd0);
    check("full_cnt0", cnt0, 32'd6);

    // Concurrent push/pop across the pointer wrap
    o0_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b0;
    in_data = 32'd100; cycle(1);
    in_data = 32'd101; cycle(1);
    o0_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 32'd102 + i;
      check("conc_head", o0_data, 32'd100 + i);
      check("conc_occupancy", q0.size(), 32'd2);
      cycle(1);
    end
    in_valid = 1'b0;
    cycle(3);
    check("conc_cnt0", cnt0, 32'd28);

    // Asynchronous reset mid-operation with output 1 holding 3 words
    o1_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'hC0DE_0000 + i;
      cycle(1);
    end
    in_valid = 1'b0;
    check("mid_o1_valid_pre", {31'd0, o1_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_o1_valid", {31'd0, o1_valid}, 32'd0);
    check("mid_cnt1", cnt1, 32'd0);
    check("mid_cnt0", cnt0, 32'd0);
    check("mid_o1_data", o1_data, 32'd0);
    cycle(2);
    rst_n = 1'b1;
    o1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("mid_no_stale", {31'd0, o1_valid}, 32'd0);
      cycle(1);
    end
    check("mid_cnt1_after", cnt1, 32'd0);

    // Counter wrap
    o0_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEAD_BEEF;
    cycle(1);
    in_valid = 1'b0;
    force dut.cnt0_q = 32'hFFFF_FFFF;
    m_cnt0 = 32'hFFFF_FFFF;
    #1 release dut.cnt0_q;
    check("wrap_pre", cnt0, 32'hFFFF_FFFF);
    o0_ready = 1'b1;
    cycle(1);
    check("wrap_cnt0", cnt0, 32'd0);
    cycle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_demux1t2_32_stream
